// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Brief    : Shared register-file constants and index-width helper used by
//            the writeback arbiter and its round-robin sub-arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int RF_AW        = 5;
  localparam int RF_DW        = 32;
  localparam int RF_ZERO_ADDR = 0;

  // Width of an index into n requesters; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RF_NREQ_DEFAULT = 3;
  localparam int RF_IDX_W        = idx_width(RF_NREQ_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter. Scans the request vector
//            starting at rr_ptr (wrapping) and grants the first set bit.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import rf_pkg::*;
#(
  parameter  int NREQ = 3,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_grant
);

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [IW-1:0]   w_j;
  int              w_pos;

  // Priority scan from rr_ptr, first full slot wins.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    w_j     = '0;
    w_pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = int'(rr_ptr) + k;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      w_j = IW'(w_pos);
      if (!w_any && req[w_j]) begin
        w_any        = 1'b1;
        w_grant[w_j] = 1'b1;
        w_idx        = w_j;
      end
    end
  end

  assign grant     = w_grant;
  assign grant_idx = w_idx;
  assign any_grant = w_any;

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Shares the register file write port between NREQ writeback
//            sources. One holding slot per source, round-robin drain of one
//            slot per cycle, writes to r0 dropped at acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter  int NREQ = 3,
  parameter  int AW   = RF_AW,
  parameter  int DW   = RF_DW,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [DW-1:0]    rf_din,
  output logic [IW-1:0]    grant_id,
  output logic [NREQ-1:0]  slot_full
);

  localparam logic [IW-1:0] c_last_idx = IW'(NREQ - 1);
  localparam logic [AW-1:0] c_zero_addr = AW'(RF_ZERO_ADDR);

  logic [NREQ-1:0] r_full;
  logic [AW-1:0]   r_addr [NREQ];
  logic [DW-1:0]   r_data [NREQ];
  logic [IW-1:0]   r_ptr;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_gidx;
  logic            w_any;
  logic [NREQ-1:0] w_ready;
  logic [NREQ-1:0] w_load;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req       (r_full),
    .rr_ptr    (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any_grant (w_any)
  );

  // A slot being drained this cycle may be refilled at the same edge.
  assign w_ready = ~r_full | w_grant;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
      logic [AW-1:0] w_in_addr;
      logic [DW-1:0] w_in_data;

      assign w_in_addr  = req_addr[gi*AW +: AW];
      assign w_in_data  = req_data[gi*DW +: DW];
      // Handshake to r0 completes but never occupies the slot.
      assign w_load[gi] = req_valid[gi] & w_ready[gi] & (w_in_addr != c_zero_addr);

      // Occupancy: set on load, cleared when granted and not reloaded.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_full[gi] <= 1'b0;
        end else if (w_load[gi]) begin
          r_full[gi] <= 1'b1;
        end else if (w_grant[gi]) begin
          r_full[gi] <= 1'b0;
        end
      end

      // Slot payload; contents only meaningful while the full bit is set.
      always_ff @(posedge clk) begin
        if (w_load[gi]) begin
          r_addr[gi] <= w_in_addr;
          r_data[gi] <= w_in_data;
        end
      end
    end
  endgenerate

  // Round-robin pointer moves just past the winner, holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_gidx == c_last_idx) ? '0 : w_gidx + 1'b1;
    end
  end

  assign req_ready = w_ready;
  assign slot_full = r_full;
  assign rf_we     = w_any;
  assign rf_waddr  = w_any ? r_addr[w_gidx] : '0;
  assign rf_din    = w_any ? r_data[w_gidx] : '0;
  assign grant_id  = w_gidx;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Brief    : Directed, table-driven self-checking bench for rf_wb_arbiter
//            (NREQ=3, AW=5, DW=32) with a small register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_din;
  logic [1:0]  grant_id;
  logic [2:0]  slot_full;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  logic [31:0] rf_model [32];

  localparam logic [31:0] c_a = 32'hAAAA0001;
  localparam logic [31:0] c_b = 32'hBBBB0002;
  localparam logic [31:0] c_c = 32'hCCCC0003;
  localparam logic [31:0] c_x = 32'h11110000;
  localparam logic [31:0] c_y = 32'h22220000;

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] din;
    logic [1:0]  gid;
    logic [2:0]  full;
    logic [2:0]  ready;
  } vec_t;

  vec_t vecs[$];

  rf_wb_arbiter #(
    .NREQ (3),
    .AW   (5),
    .DW   (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_din    (rf_din),
    .grant_id  (grant_id),
    .slot_full (slot_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v,
                              input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0,
                              input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                              input logic we, input logic [4:0] wa, input logic [31:0] din,
                              input logic [1:0] gid, input logic [2:0] full, input logic [2:0] rdy);
    vec_t t;
    t.valid = v;
    t.addr  = {a2, a1, a0};
    t.data  = {d2, d1, d0};
    t.we    = we;
    t.waddr = wa;
    t.din   = din;
    t.gid   = gid;
    t.full  = full;
    t.ready = rdy;
    return t;
  endfunction

  task automatic check_outs(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] din, input logic [1:0] gid,
                            input logic [2:0] full, input logic [2:0] rdy);
    chk({tag, " rf_we"},     32'(rf_we),     32'(we));
    chk({tag, " rf_waddr"},  32'(rf_waddr),  32'(wa));
    chk({tag, " rf_din"},    rf_din,         din);
    chk({tag, " grant_id"},  32'(grant_id),  32'(gid));
    chk({tag, " slot_full"}, 32'(slot_full), 32'(full));
    chk({tag, " req_ready"}, 32'(req_ready), 32'(rdy));
  endtask

  // Drive one vector for one cycle, check before the edge, log the write.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    req_valid = v.valid;
    req_addr  = v.addr;
    req_data  = v.data;
    #1;
    check_outs($sformatf("v%0d", idx), v.we, v.waddr, v.din, v.gid, v.full, v.ready);
    if (rf_we) begin
      n_writes++;
      if (rf_waddr != 5'd0) rf_model[rf_waddr] = rf_din;
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf_model[r] = 32'h0;

    // v1..v3: drain three slots loaded at reset release, order 0,1,2
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0, 1'b1, 5'd1, 32'h11, 2'd0, 3'b111, 3'b001));
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0, 1'b1, 5'd2, 32'h22, 2'd1, 3'b110, 3'b011));
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0, 1'b1, 5'd3, 32'h33, 2'd2, 3'b100, 3'b111));
    // v4..v6: reload slots 0 and 2, order 0 then 2
    vecs.push_back(mk(3'b101, 6,0,4, 32'h66,0,32'h44, 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111));
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0, 1'b1, 5'd4, 32'h44, 2'd0, 3'b101, 3'b011));
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0, 1'b1, 5'd6, 32'h66, 2'd2, 3'b100, 3'b111));
    // v7..v10: requester 1 streams 5/A, 6/B, 7/C back-to-back
    vecs.push_back(mk(3'b010, 0,5,0, 0,c_a,0, 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111));
    vecs.push_back(mk(3'b010, 0,6,0, 0,c_b,0, 1'b1, 5'd5, c_a,   2'd1, 3'b010, 3'b111));
    vecs.push_back(mk(3'b010, 0,7,0, 0,c_c,0, 1'b1, 5'd6, c_b,   2'd1, 3'b010, 3'b111));
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0,   1'b1, 5'd7, c_c,   2'd1, 3'b010, 3'b111));
    // v11..v12: write to r0 is accepted and dropped
    vecs.push_back(mk(3'b100, 0,0,0, 32'hDEADBEEF,0,0, 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111));
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0, 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111));
    // v13..v18: backpressure on requester 1 while slot 0 drains
    vecs.push_back(mk(3'b100, 8,0,0, 32'h88,0,0, 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111));
    vecs.push_back(mk(3'b011, 0,11,10, 0,32'h101,32'h100, 1'b1, 5'd8, 32'h88, 2'd2, 3'b100, 3'b111));
    vecs.push_back(mk(3'b010, 0,12,0, 0,32'h102,0, 1'b1, 5'd10, 32'h100, 2'd0, 3'b011, 3'b101));
    vecs.push_back(mk(3'b010, 0,12,0, 0,32'h102,0, 1'b1, 5'd11, 32'h101, 2'd1, 3'b010, 3'b111));
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0, 1'b1, 5'd12, 32'h102, 2'd1, 3'b010, 3'b111));
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0, 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111));
    // v19..v24: bring rr_ptr to 0, then same-address conflict on r9
    vecs.push_back(mk(3'b100, 1,0,0, 32'h55,0,0, 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111));
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0, 1'b1, 5'd1, 32'h55, 2'd2, 3'b100, 3'b111));
    vecs.push_back(mk(3'b101, 9,0,9, c_y,0,c_x, 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111));
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0, 1'b1, 5'd9, c_x, 2'd0, 3'b101, 3'b011));
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0, 1'b1, 5'd9, c_y, 2'd2, 3'b100, 3'b111));
    vecs.push_back(mk(3'b000, 0,0,0, 0,0,0, 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111));

    // Reset held with all requesters valid: nothing accepted, nothing written.
    rst       = 1'b0;
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    repeat (3) @(negedge clk);
    #1;
    check_outs("reset", 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111);

    // Release reset; the next edge accepts all three requests.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs("release", 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    chk("r9 last grant wins", rf_model[9], c_y);
    chk("r5 stream",          rf_model[5], c_a);
    chk("r6 stream",          rf_model[6], c_b);
    chk("r7 stream",          rf_model[7], c_c);
    chk("r11 old data",       rf_model[11], 32'h101);
    chk("r12 held request",   rf_model[12], 32'h102);
    chk("r0 untouched",       rf_model[0], 32'h0);
    chk("write count",        32'(n_writes), 32'd15);

    // Reset asserted mid-operation drops pending slots without a write.
    @(negedge clk);
    req_valid = 3'b011;
    req_addr  = {5'd0, 5'd14, 5'd13};
    req_data  = {32'h0, 32'h140, 32'h130};
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    check_outs("preabort", 1'b1, 5'd13, 32'h130, 2'd0, 3'b011, 3'b101);
    #1;
    rst = 1'b0;
    #1;
    check_outs("abort", 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs("postabort", 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b111);
    @(negedge clk);
    #1;
    chk("postabort2 rf_we", 32'(rf_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
